// File: rtl/seg7_pkg.sv
// Shared 7-segment glyph constants, digit slot indices and the BCD value record.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg7_pkg;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_MINUS = 7'b1000000;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Digit slot order of the scan
    typedef logic [1:0] dig_idx_t;
    localparam dig_idx_t DIG_ONES = 2'd0;
    localparam dig_idx_t DIG_TENS = 2'd1;
    localparam dig_idx_t DIG_HUND = 2'd2;
    localparam dig_idx_t DIG_SIGN = 2'd3;

    // One complete display value as delivered by the BCD stage
    typedef struct packed {
        logic       neg;
        logic [1:0] hund;
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_val_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-high 7-segment glyph; values above 9 render as 'E'.
// Latency: purely combinational.
// Backpressure: none.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Glyph lookup; anything that is not legal BCD shows the error glyph
    always_comb begin
        seg_o = SEG_E;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_E;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// 4-digit multiplexed 7-seg driver (sign/hundreds/tens/ones) with shadow+display double buffer.
// Latency: SEG/AN registered, one cycle behind the digit index; shadow commits at frame wrap.
// Backpressure: none; LOAD is a strobe, later loads overwrite the shadow (last wins).
module bcd_display_scanner
    import seg7_pkg::*;
#(
    parameter logic [15:0] REFRESH_DIV    = 16'd50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    parameter bit          BLANK_LZ       = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] ONES,
    input  logic [3:0] TENS,
    input  logic [1:0] HUNDREDS,
    input  logic       NEG,
    input  logic       LOAD,
    output logic [6:0] SEG,
    output logic [3:0] AN,
    output logic       FRAME,
    output logic       PENDING
);

    // Physical "all off" levels for the pins
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;

    logic [15:0] cnt_q, cnt_d;
    dig_idx_t    idx_q, idx_d;
    logic        started_q, started_d;
    logic        frame_q, frame_d;
    logic        pending_q, pending_d;
    bcd_val_t    shadow_q, shadow_d;
    bcd_val_t    disp_q, disp_d;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d;

    logic        tick;
    logic        wrap;
    bcd_val_t    live;
    logic [3:0]  sel_bcd;
    logic [6:0]  glyph;
    logic [6:0]  digit_seg;
    logic [3:0]  an_onehot;

    assign live = '{neg: NEG, hund: HUNDREDS, tens: TENS, ones: ONES};

    // Prescaler and digit index; started latches the first tick so AN stays dark until then
    always_comb begin
        tick      = (cnt_q == (REFRESH_DIV - 16'd1));
        wrap      = tick && (idx_q == DIG_SIGN);
        cnt_d     = tick ? 16'd0 : (cnt_q + 16'd1);
        idx_d     = tick ? (idx_q + 2'd1) : idx_q;
        started_d = started_q | tick;
        frame_d   = wrap;
    end

    // Double buffer: LOAD fills the shadow, wrap commits it; LOAD on the wrap edge bypasses
    always_comb begin
        shadow_d  = shadow_q;
        disp_d    = disp_q;
        pending_d = pending_q;
        if (LOAD) begin
            shadow_d = live;
        end
        if (wrap) begin
            pending_d = 1'b0;
            if (LOAD) begin
                disp_d = live;
            end else if (pending_q) begin
                disp_d = shadow_q;
            end
        end else if (LOAD) begin
            pending_d = 1'b1;
        end
    end

    // Pick the digit for the current slot and decide leading-zero blanking
    always_comb begin
        sel_bcd   = disp_q.ones;
        digit_seg = glyph;
        case (idx_q)
            DIG_ONES: begin
                sel_bcd   = disp_q.ones;
                digit_seg = glyph;
            end
            DIG_TENS: begin
                sel_bcd   = disp_q.tens;
                digit_seg = (BLANK_LZ && (disp_q.hund == 2'd0) && (disp_q.tens == 4'd0))
                            ? SEG_BLANK : glyph;
            end
            DIG_HUND: begin
                sel_bcd   = {2'b00, disp_q.hund};
                digit_seg = (BLANK_LZ && (disp_q.hund == 2'd0)) ? SEG_BLANK : glyph;
            end
            default: begin
                sel_bcd   = disp_q.ones;
                digit_seg = disp_q.neg ? SEG_MINUS : SEG_BLANK;
            end
        endcase
    end

    bcd_to_seg7 u_glyph (
        .bcd_i (sel_bcd),
        .seg_o (glyph)
    );

    // Output register: SEG and AN move together; pin polarity is applied only here
    always_comb begin
        an_onehot = 4'b0001 << idx_q;
        seg_d     = SEG_OFF;
        an_d      = AN_OFF;
        if (started_q || tick) begin
            seg_d = SEG_ACTIVE_LOW ? ~digit_seg : digit_seg;
            an_d  = AN_ACTIVE_LOW  ? ~an_onehot : an_onehot;
        end
    end

    // State registers; reset blanks the display and loses any stored value
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q     <= 16'd0;
            idx_q     <= DIG_ONES;
            started_q <= 1'b0;
            frame_q   <= 1'b0;
            pending_q <= 1'b0;
            shadow_q  <= '0;
            disp_q    <= '0;
            seg_q     <= SEG_OFF;
            an_q      <= AN_OFF;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            started_q <= started_d;
            frame_q   <= frame_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign SEG     = seg_q;
    assign AN      = an_q;
    assign FRAME   = frame_q;
    assign PENDING = pending_q;

endmodule
